// File: rtl/adder_result_fifo.sv
// adder_result_fifo: captures registered-adder results into a small first-word-fall-through FIFO.
// Results arriving while the FIFO is full and not draining are dropped and counted.
`default_nettype none

module adder_result_fifo #(
    parameter int g_data_width = 6,
    parameter int g_depth      = 4,
    parameter int g_cnt_width  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [g_data_width:0]         i_data,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [g_data_width:0]         o_data,
    output logic [$clog2(g_depth):0]      o_level,
    output logic                          o_overflow,
    output logic [g_cnt_width-1:0]        o_drop_cnt
);

    localparam int AW = $clog2(g_depth);
    localparam int LW = AW + 1;
    localparam int DW = g_data_width + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(g_depth);

    logic [DW-1:0]          mem [g_depth];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level;
    logic                   overflow;
    logic [g_cnt_width-1:0] drop_cnt;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    // Full/empty come from the level counter so pointer equality is never ambiguous.
    always_comb begin
        full  = (level == FULL_LEVEL);
        empty = (level == '0);
        pop   = !empty && i_ready;
        push  = i_valid && (!full || pop);
        drop  = i_valid && full && !pop;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + g_cnt_width'(1);
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the level counter.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_comb begin
        o_valid    = !empty;
        o_data     = empty ? '0 : mem[rd_ptr];
        o_level    = level;
        o_overflow = overflow;
        o_drop_cnt = drop_cnt;
    end

endmodule

`default_nettype wire
